// File: rtl/dircc_dual_port_proc_mem.sv
// Mixed-width dual-port processing memory: wide s1 / narrow s2 Avalon-MM slaves, post-reset clear.
// Optional DIRCC_MEM_OUTREG_EN adds an output register on both read ports (latency 2).
module dircc_dual_port_proc_mem #(
    parameter int DATA_W         = 32,
    parameter int RATIO          = 2,
    parameter int DEPTH          = 7500,
    parameter int ADDR_W_A       = $clog2(DEPTH),
    parameter int ADDR_W_B       = $clog2(DEPTH*RATIO),
    parameter bit CLEAR_ON_RESET = 1'b1,
    parameter     INIT_FILE      = ""
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       reset_req,
    input  logic [ADDR_W_A-1:0]        address,
    input  logic                       chipselect,
    input  logic                       write,
    input  logic                       read,
    input  logic                       clken,
    input  logic [DATA_W/8-1:0]        byteenable,
    input  logic [DATA_W-1:0]          writedata,
    output logic [DATA_W-1:0]          readdata,
    output logic                       readdatavalid,
    output logic                       waitrequest,
    input  logic [ADDR_W_B-1:0]        address2,
    input  logic                       chipselect2,
    input  logic                       write2,
    input  logic                       read2,
    input  logic                       clken2,
    input  logic [DATA_W/RATIO/8-1:0]  byteenable2,
    input  logic [DATA_W/RATIO-1:0]    writedata2,
    output logic [DATA_W/RATIO-1:0]    readdata2,
    output logic                       readdatavalid2,
    output logic                       waitrequest2,
    output logic                       init_done,
    output logic                       range_err,
    output logic [15:0]                collision_count
);

    localparam int NB    = DATA_W / 8;
    localparam int NW    = DATA_W / RATIO;
    localparam int NB2   = NW / 8;
    localparam int LW    = $clog2(RATIO);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_RESET, S_CLEAR, S_READY} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              clr_we;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc_a, acc_b, wr_a, wr_b, rd_a, rd_b;
    logic              oor_a, oor_b, wr_a_ok, wr_b_ok, coll;
    logic [IDX_W-1:0]  idx_a, idx_b;
    logic [ADDR_W_B-1:0] wsh_b;
    logic [LW-1:0]     lane_b;
    logic [NB-1:0]     be_bw;
    logic [DATA_W-1:0] wd_bw;

    logic              rv_a_q, rv_b_q, range_q;
    logic [DATA_W-1:0] rd_a_q;
    logic [NW-1:0]     rd_b_q;
    logic [15:0]       coll_q;

    assign init_done    = (state_q == S_READY);
    assign waitrequest  = ~init_done | reset_req;
    assign waitrequest2 = ~init_done | reset_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        unique case (state_q)
            S_RESET: begin
                cnt_d   = '0;
                state_d = CLEAR_ON_RESET ? S_CLEAR : S_READY;
            end
            S_CLEAR: begin
                if (!reset_req) begin
                    clr_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(DEPTH - 1))
                        state_d = S_READY;
                end
            end
            S_READY: state_d = S_READY;
            default: state_d = S_RESET;
        endcase
    end

    assign acc_a = chipselect & (read | write) & clken & ~waitrequest;
    assign acc_b = chipselect2 & (read2 | write2) & clken2 & ~waitrequest2;
    assign wr_a  = acc_a & write;
    assign wr_b  = acc_b & write2;
    assign rd_a  = acc_a & ~write;
    assign rd_b  = acc_b & ~write2;

    assign oor_a  = 32'(address) >= 32'(DEPTH);
    assign oor_b  = 32'(address2) >= 32'(DEPTH * RATIO);
    assign idx_a  = IDX_W'(address);
    assign wsh_b  = address2 >> LW;
    assign idx_b  = IDX_W'(wsh_b);
    assign lane_b = address2[LW-1:0];

    assign wr_a_ok = wr_a & ~oor_a;
    assign wr_b_ok = wr_b & ~oor_b;
    assign wd_bw   = {RATIO{writedata2}};

    always_comb begin
        be_bw = '0;
        for (int l = 0; l < RATIO; l++) begin
            if (lane_b == LW'(l))
                be_bw[l*NB2 +: NB2] = byteenable2;
        end
    end

    assign coll = wr_a_ok & wr_b_ok & (idx_a == idx_b) & (|(byteenable & be_bw));

    // s1 lanes are written after s2 so overlapping bytes resolve to s1
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[cnt_q] <= '0;
        for (int i = 0; i < NB; i++) begin
            if (wr_b_ok && be_bw[i])
                mem[idx_b][8*i +: 8] <= wd_bw[8*i +: 8];
            if (wr_a_ok && byteenable[i])
                mem[idx_a][8*i +: 8] <= writedata[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rv_a_q  <= 1'b0;
            rv_b_q  <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            range_q <= 1'b0;
            coll_q  <= '0;
        end else begin
            if (!reset_req) begin
                rv_a_q <= rd_a;
                rv_b_q <= rd_b;
                if (rd_a)
                    rd_a_q <= oor_a ? '0 : mem[idx_a];
                if (rd_b)
                    rd_b_q <= oor_b ? '0 : mem[idx_b][int'(lane_b)*NW +: NW];
            end
            if ((acc_a && oor_a) || (acc_b && oor_b))
                range_q <= 1'b1;
            if (coll && coll_q != 16'hFFFF)
                coll_q <= coll_q + 16'd1;
        end
    end

    assign range_err       = range_q;
    assign collision_count = coll_q;

`ifdef DIRCC_MEM_OUTREG_EN
    logic              ov_a_q, ov_b_q;
    logic [DATA_W-1:0] od_a_q;
    logic [NW-1:0]     od_b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            ov_a_q <= 1'b0;
            ov_b_q <= 1'b0;
            od_a_q <= '0;
            od_b_q <= '0;
        end else if (!reset_req) begin
            ov_a_q <= rv_a_q;
            ov_b_q <= rv_b_q;
            if (rv_a_q)
                od_a_q <= rd_a_q;
            if (rv_b_q)
                od_b_q <= rd_b_q;
        end
    end

    assign readdata       = od_a_q;
    assign readdata2      = od_b_q;
    assign readdatavalid  = ov_a_q & ~reset_req;
    assign readdatavalid2 = ov_b_q & ~reset_req;
`else
    // valid is masked while frozen so it is delivered once reset_req drops
    assign readdata       = rd_a_q;
    assign readdata2      = rd_b_q;
    assign readdatavalid  = rv_a_q & ~reset_req;
    assign readdatavalid2 = rv_b_q & ~reset_req;
`endif

endmodule

// File: tb/tb_dircc_dual_port_proc_mem.sv
// Directed self-checking bench for dircc_dual_port_proc_mem (DEPTH=16, widened addresses).
module tb_dircc_dual_port_proc_mem;

`ifdef DIRCC_MEM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        reset, reset_req;
    logic [4:0]  address;
    logic        chipselect, write, read, clken;
    logic [3:0]  byteenable;
    logic [31:0] writedata, readdata;
    logic        readdatavalid, waitrequest;
    logic [5:0]  address2;
    logic        chipselect2, write2, read2, clken2;
    logic [1:0]  byteenable2;
    logic [15:0] writedata2, readdata2;
    logic        readdatavalid2, waitrequest2;
    logic        init_done, range_err;
    logic [15:0] collision_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dircc_dual_port_proc_mem #(
        .DATA_W(32), .RATIO(2), .DEPTH(16),
        .ADDR_W_A(5), .ADDR_W_B(6), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .reset_req(reset_req),
        .address(address), .chipselect(chipselect), .write(write),
        .read(read), .clken(clken), .byteenable(byteenable),
        .writedata(writedata), .readdata(readdata),
        .readdatavalid(readdatavalid), .waitrequest(waitrequest),
        .address2(address2), .chipselect2(chipselect2), .write2(write2),
        .read2(read2), .clken2(clken2), .byteenable2(byteenable2),
        .writedata2(writedata2), .readdata2(readdata2),
        .readdatavalid2(readdatavalid2), .waitrequest2(waitrequest2),
        .init_done(init_done), .range_err(range_err),
        .collision_count(collision_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(output int n);
        n = 0;
        while (!init_done && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        chipselect = 1; write = 1; read = 0; address = a; writedata = d; byteenable = be;
        step();
        chipselect = 0; write = 0;
    endtask

    task automatic wr2(input logic [5:0] a, input logic [15:0] d, input logic [1:0] be);
        chipselect2 = 1; write2 = 1; read2 = 0; address2 = a; writedata2 = d; byteenable2 = be;
        step();
        chipselect2 = 0; write2 = 0;
    endtask

    task automatic rd1(input logic [4:0] a, output logic [31:0] d, output int lat);
        chipselect = 1; read = 1; write = 0; address = a;
        step();
        chipselect = 0; read = 0;
        lat = 1;
        while (!readdatavalid && lat < 10) begin
            step();
            lat++;
        end
        d = readdata;
    endtask

    task automatic rd2(input logic [5:0] a, output logic [15:0] d, output int lat);
        chipselect2 = 1; read2 = 1; write2 = 0; address2 = a;
        step();
        chipselect2 = 0; read2 = 0;
        lat = 1;
        while (!readdatavalid2 && lat < 10) begin
            step();
            lat++;
        end
        d = readdata2;
    endtask

    task automatic test_reset();
        int n;
        logic [31:0] d;
        int lat;
        reset = 1;
        repeat (3) step();
        checks++;
        if (waitrequest !== 1'b1 || waitrequest2 !== 1'b1 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl: wr=%b wr2=%b init=%b required 1 1 0", waitrequest, waitrequest2, init_done);
        end
        checks++;
        if (readdatavalid !== 1'b0 || readdatavalid2 !== 1'b0 || readdata !== 32'h0 || readdata2 !== 16'h0) begin
            errors++;
            $display("FAIL reset_rd: v=%b v2=%b d=%h d2=%h required 0 0 0 0", readdatavalid, readdatavalid2, readdata, readdata2);
        end
        checks++;
        if (range_err !== 1'b0 || collision_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_err: range=%b coll=%h required 0 0000", range_err, collision_count);
        end
        reset = 0;
        wait_init(n);
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL init_latency: got %0d cycles required 17", n);
        end
        rd1(5'd5, d, lat);
        checks++;
        if (d !== 32'h0 || lat != LAT) begin
            errors++;
            $display("FAIL clear_read5: got %h lat %0d required 00000000 lat %0d", d, lat, LAT);
        end
    endtask

    task automatic test_clear_restart();
        int n;
        logic [31:0] d;
        int lat;
        wr1(5'd0, 32'h12345678, 4'hF);
        wr1(5'd15, 32'h9ABCDEF0, 4'hF);
        reset = 1;
        step();
        reset = 0;
        repeat (9) step();
        reset = 1;
        step();
        reset = 0;
        wait_init(n);
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL clear_restart: got %0d cycles required 17", n);
        end
        rd1(5'd0, d, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL clear_addr0: got %h required 00000000", d);
        end
        wr1(5'd15, 32'h9ABCDEF0, 4'hF);
        reset = 1;
        step();
        reset = 0;
        repeat (5) step();
        reset_req = 1;
        repeat (3) step();
        reset_req = 0;
        wait_init(n);
        n += 8;
        checks++;
        if (n != 20) begin
            errors++;
            $display("FAIL clear_freeze: got %0d cycles required 20", n);
        end
        rd1(5'd15, d, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL clear_addr15: got %h required 00000000", d);
        end
    endtask

    task automatic test_write_lanes();
        logic [15:0] h;
        logic [31:0] d;
        int lat;
        wr1(5'd3, 32'hDEADBEEF, 4'hF);
        rd2(6'd6, h, lat);
        checks++;
        if (h !== 16'hBEEF || lat != LAT) begin
            errors++;
            $display("FAIL s2_lane0: got %h lat %0d required beef lat %0d", h, lat, LAT);
        end
        rd2(6'd7, h, lat);
        checks++;
        if (h !== 16'hDEAD || lat != LAT) begin
            errors++;
            $display("FAIL s2_lane1: got %h lat %0d required dead lat %0d", h, lat, LAT);
        end
        wr1(5'd9, 32'h11111111, 4'hF);
        wr1(5'd9, 32'h22222222, 4'h4);
        wr1(5'd9, 32'hFFFFFFFF, 4'h0);
        wr2(6'd19, 16'h3300, 2'b10);
        rd1(5'd9, d, lat);
        checks++;
        if (d !== 32'h33221111) begin
            errors++;
            $display("FAIL byteenable: got %h required 33221111", d);
        end
    endtask

    task automatic test_collision();
        logic [31:0] d;
        int lat;
        chipselect = 1; write = 1; address = 5'd2; writedata = 32'h11223344; byteenable = 4'h3;
        chipselect2 = 1; write2 = 1; address2 = 6'd4; writedata2 = 16'hAAAA; byteenable2 = 2'b11;
        step();
        address2 = 6'd5; writedata2 = 16'hBBBB; writedata = 32'h11225566;
        step();
        checks++;
        if (collision_count !== 16'd1) begin
            errors++;
            $display("FAIL coll_count1: got %0d required 1", collision_count);
        end
        address2 = 6'd4; writedata2 = 16'hDDEE; writedata = 32'h000000CC; byteenable = 4'h1;
        step();
        chipselect = 0; write = 0; chipselect2 = 0; write2 = 0;
        checks++;
        if (collision_count !== 16'd2) begin
            errors++;
            $display("FAIL coll_count2: got %0d required 2", collision_count);
        end
        rd1(5'd2, d, lat);
        checks++;
        if (d !== 32'hBBBBDDCC) begin
            errors++;
            $display("FAIL coll_word: got %h required bbbbddcc", d);
        end
    endtask

    task automatic test_read_during_write();
        logic [31:0] d;
        int lat;
        chipselect = 1; read = 1; write = 0; address = 5'd3;
        chipselect2 = 1; write2 = 1; address2 = 6'd6; writedata2 = 16'h5555; byteenable2 = 2'b11;
        step();
        chipselect = 0; read = 0; chipselect2 = 0; write2 = 0;
        lat = 1;
        while (!readdatavalid && lat < 10) begin
            step();
            lat++;
        end
        checks++;
        if (readdata !== 32'hDEADBEEF || lat != LAT) begin
            errors++;
            $display("FAIL rdw_old: got %h lat %0d required deadbeef lat %0d", readdata, lat, LAT);
        end
        rd1(5'd3, d, lat);
        checks++;
        if (d !== 32'hDEAD5555) begin
            errors++;
            $display("FAIL rdw_new: got %h required dead5555", d);
        end
    endtask

    task automatic test_range();
        logic [31:0] d;
        logic [15:0] h;
        int lat;
        checks++;
        if (range_err !== 1'b0) begin
            errors++;
            $display("FAIL range_pre: got %b required 0", range_err);
        end
        wr1(5'd20, 32'hCAFEF00D, 4'hF);
        checks++;
        if (range_err !== 1'b1) begin
            errors++;
            $display("FAIL range_set: got %b required 1", range_err);
        end
        rd1(5'd4, d, lat);
        checks++;
        if (d !== 32'h0) begin
            errors++;
            $display("FAIL range_drop: got %h required 00000000", d);
        end
        wr1(5'd0, 32'h77777777, 4'hF);
        rd1(5'd20, d, lat);
        checks++;
        if (d !== 32'h0 || lat != LAT) begin
            errors++;
            $display("FAIL range_rd1: got %h lat %0d required 00000000 lat %0d", d, lat, LAT);
        end
        wr2(6'd0, 16'h6666, 2'b11);
        rd2(6'd40, h, lat);
        checks++;
        if (h !== 16'h0 || lat != LAT) begin
            errors++;
            $display("FAIL range_rd2: got %h lat %0d required 0000 lat %0d", h, lat, LAT);
        end
    endtask

    task automatic test_reset_req_read();
        int n;
        chipselect = 1; read = 1; write = 0; address = 5'd3;
        step();
        chipselect = 0; read = 0;
        reset_req = 1;
        #1;
        checks++;
        if (readdatavalid !== 1'b0 || waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL rreq_hold: v=%b wr=%b required 0 1", readdatavalid, waitrequest);
        end
        repeat (3) step();
        reset_req = 0;
        #1;
        n = 0;
        while (!readdatavalid && n < 10) begin
            step();
            n++;
        end
        checks++;
        if (n != LAT - 1 || readdata !== 32'hDEAD5555) begin
            errors++;
            $display("FAIL rreq_defer: got %h after %0d required dead5555 after %0d", readdata, n, LAT - 1);
        end
        step();
        checks++;
        if (readdatavalid !== 1'b0) begin
            errors++;
            $display("FAIL rreq_pulse: valid %b required 0", readdatavalid);
        end
    endtask

    task automatic test_back_to_back();
        logic        vs [5];
        logic [15:0] ds [5];
        chipselect2 = 1; read2 = 1; write2 = 0; address2 = 6'd6;
        step();
        vs[0] = readdatavalid2; ds[0] = readdata2;
        address2 = 6'd7;
        step();
        vs[1] = readdatavalid2; ds[1] = readdata2;
        chipselect2 = 0; read2 = 0;
        for (int i = 2; i < 5; i++) begin
            step();
            vs[i] = readdatavalid2; ds[i] = readdata2;
        end
        checks++;
        if (vs[LAT-1] !== 1'b1 || ds[LAT-1] !== 16'h5555) begin
            errors++;
            $display("FAIL b2b_first: v=%b d=%h required 1 5555", vs[LAT-1], ds[LAT-1]);
        end
        checks++;
        if (vs[LAT] !== 1'b1 || ds[LAT] !== 16'hDEAD) begin
            errors++;
            $display("FAIL b2b_second: v=%b d=%h required 1 dead", vs[LAT], ds[LAT]);
        end
        checks++;
        if (vs[LAT+1] !== 1'b0 || ds[LAT+2] !== 16'hDEAD) begin
            errors++;
            $display("FAIL b2b_hold: v=%b d=%h required 0 dead", vs[LAT+1], ds[LAT+2]);
        end
    endtask

    task automatic test_clken();
        int nv;
        chipselect = 1; read = 1; write = 0; address = 5'd3; clken = 0;
        chipselect2 = 1; write2 = 1; address2 = 6'd6; writedata2 = 16'h0000; byteenable2 = 2'b11; clken2 = 0;
        step();
        chipselect = 0; read = 0; clken = 1;
        chipselect2 = 0; write2 = 0; clken2 = 1;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            if (readdatavalid) nv++;
            step();
        end
        checks++;
        if (nv != 0) begin
            errors++;
            $display("FAIL clken_stall: %0d valids required 0", nv);
        end
        write = 0;
        chipselect2 = 1; read2 = 1; address2 = 6'd6;
        step();
        chipselect2 = 0; read2 = 0;
        nv = 0;
        while (!readdatavalid2 && nv < 10) begin
            step();
            nv++;
        end
        checks++;
        if (readdata2 !== 16'h5555) begin
            errors++;
            $display("FAIL clken_nowrite: got %h required 5555", readdata2);
        end
    endtask

    task automatic test_final_reset();
        int n;
        reset = 1;
        repeat (2) step();
        checks++;
        if (range_err !== 1'b0 || collision_count !== 16'h0 || readdata !== 32'h0) begin
            errors++;
            $display("FAIL rereset: range=%b coll=%h d=%h required 0 0000 00000000", range_err, collision_count, readdata);
        end
        reset = 0;
        wait_init(n);
        checks++;
        if (n != 17) begin
            errors++;
            $display("FAIL rereset_init: got %0d required 17", n);
        end
    endtask

    initial begin
        reset = 1; reset_req = 0;
        address = '0; chipselect = 0; write = 0; read = 0; clken = 1;
        byteenable = '0; writedata = '0;
        address2 = '0; chipselect2 = 0; write2 = 0; read2 = 0; clken2 = 1;
        byteenable2 = '0; writedata2 = '0;
        test_reset();
        test_clear_restart();
        test_write_lanes();
        test_collision();
        test_read_during_write();
        test_range();
        test_reset_req_read();
        test_back_to_back();
        test_clken();
        test_final_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dircc_dual_port_proc_mem.md
# dircc_dual_port_proc_mem

Parametrised mixed-width dual-port processing memory for a DiRCC node: two Avalon-MM slaves (s1 wide, s2 narrow) share one inferred RAM sharing one clock. Adds, relative to the fixed-geometry generation: configurable width/ratio/depth, explicit `waitrequest`/`readdatavalid` handshakes, a post-reset zero-clear FSM, out-of-range protection and write-write collision resolution with a saturating collision counter. Sits between the node's Nios II data master (s1) and the mailbox/DMA side (s2).

## Interface
- `DATA_W`, 32, s1 word width; multiple of 8.
- `RATIO`, 2, s1/s2 width ratio; power of two, `DATA_W/RATIO` ≥ 8.
- `DEPTH`, 7500, s1 word count.
- `ADDR_W_A`, `$clog2(DEPTH)`, s1 address width.
- `ADDR_W_B`, `$clog2(DEPTH*RATIO)`, s2 address width.
- `CLEAR_ON_RESET`, 1, 1: zero RAM after reset; 0: keep `INIT_FILE` contents.
- `INIT_FILE`, "", hex image loaded at configuration.

- `clk` in 1 — single clock.
- `reset` in 1 — synchronous, active-high.
- `reset_req` in 1 — high: whole block stalls (RAM clock enable low).
- `address`/`address2` in ADDR_W_A/ADDR_W_B — word addresses.
- `chipselect`/`chipselect2`, `write`/`write2`, `read`/`read2`, `clken`/`clken2` in 1 each.
- `byteenable`/`byteenable2` in DATA_W/8 / DATA_W/RATIO/8.
- `writedata`/`writedata2` in DATA_W / DATA_W/RATIO.
- `readdata`/`readdata2` out DATA_W / DATA_W/RATIO.
- `readdatavalid`/`readdatavalid2` out 1.
- `waitrequest`/`waitrequest2` out 1.
- `init_done` out 1 — RAM ready.
- `range_err` out 1 — sticky; out-of-range access seen.
- `collision_count` out 16 — saturating write-write collision count.

## Operation
- Request on port X accepted in cycle where `chipselect & (read|write) & clken & ~waitrequest & ~reset_req`; `read` and `write` both high → write only.
- s2 word `b` maps to s1 word `b/RATIO`, lane `b%RATIO`; lane 0 = bits [DATA_W/RATIO-1:0].
- Writes honour byte enables; all-zero byteenable write is accepted, no RAM change.
- Mixed-port read-during-write returns OLD data; same-port read-during-write not possible (write wins).
- Same-cycle writes to same s1 word with overlapping bytes: s1 bytes win, s2 writes non-overlapping bytes only; `collision_count` +1, saturates at 0xFFFF.
- Address ≥ DEPTH (s1) or ≥ DEPTH*RATIO (s2): write dropped, read returns 0 with normal `readdatavalid`, `range_err` set until `reset`.
- `clken` low: request not accepted (address stall); in-flight read still completes.
- FSM: RESET → CLEAR (if CLEAR_ON_RESET) or READY. CLEAR writes 0 to s1 addresses 0..DEPTH-1 one per cycle via port A, both `waitrequest` high; after address DEPTH-1 → READY, `init_done`=1. `reset` in CLEAR restarts from address 0. `reset_req` high freezes the clear counter.

## Timing
- Reset values: `readdata*`=0, `readdatavalid*`=0, `waitrequest*`=1, `init_done`=0, `range_err`=0, `collision_count`=0.
- CLEAR_ON_RESET=1: `init_done` rises DEPTH+1 cycles after `reset` falls; =0: 1 cycle.
- `waitrequest*` = ~init_done | reset_req.
- Read latency: `readdatavalid` one cycle after acceptance (two with output register), single-cycle pulse; one read per port per cycle, fully pipelined.
- `readdata*` hold last value when `readdatavalid` low.
- `reset_req` mid-read: pipeline freezes, `readdatavalid` delivered after release.

## Configuration
- `DIRCC_MEM_OUTREG_EN` defined: extra output register on both ports; read latency 2, `readdatavalid` delayed accordingly, throughput unchanged. Undefined: latency 1.

## Test plan
- Reset, CLEAR_ON_RESET=1, DEPTH=16 → `init_done` rises 17 cycles after reset release; s1 read of addr 5 returns 0x00000000.
- s1 write 0xDEADBEEF to addr 3, byteenable 0xF; s2 reads addr 6, 7 → 0xBEEF, 0xDEAD, `readdatavalid2` 1 (2 with macro) cycle after each accept.
- Same cycle: s1 write 0x11223344 be=0x3 addr 2; s2 write 0xAAAA be=0x3 addr 4 → word 2 = 0xXXXX3344 (s1 wins), `collision_count`=1; s2 addr 5 with be=0x3 concurrently → no collision, upper half written.
- s1 read addr 3 while s2 writes 0x5555 to addr 6 same cycle → s1 readdata 0xDEADBEEF (old data); next read → 0xDEAD5555.
- s1 write addr 20 (DEPTH=16) → dropped, `range_err`=1; read addr 20 → 0 with valid pulse.
- `reset` asserted at clear address 8 → clear restarts at 0; `reset_req` held 3 cycles during read → valid deferred 3 cycles, data correct.
